// File: rtl/apb_slave.sv
// APB slave backed by a 2**ADDR_W x DATA_W register array, zero wait states.
// Define APB_SLAVE_PSLVERR_EN to add the pslverr output for access-without-setup.
module apb_slave #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic              psel,
    input  logic              penable,
    input  logic [DATA_W-1:0] pwdata,
`ifdef APB_SLAVE_PSLVERR_EN
    output logic              pslverr,
`endif
    output logic [DATA_W-1:0] prdata
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        SETUP,
        W_ENABLE,
        R_ENABLE
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] mem [DEPTH];

    logic read_setup;
    logic write_access;

    assign read_setup   = (state == SETUP) && psel && !penable && !pwrite;
    assign write_access = (state == W_ENABLE) && psel && penable && pwrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SETUP;
        end else begin
            state <= next_state;
        end
    end

    // Penable seen in SETUP is not a valid setup, so it never leaves SETUP.
    always_comb begin
        next_state = state;
        unique case (state)
            SETUP: begin
                if (psel && !penable) begin
                    next_state = pwrite ? W_ENABLE : R_ENABLE;
                end
            end
            W_ENABLE: next_state = SETUP;
            R_ENABLE: next_state = SETUP;
            default:  next_state = SETUP;
        endcase
    end

    // Read data is captured during setup so it is stable for the whole access cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prdata <= '0;
        end else if (read_setup) begin
            prdata <= mem[paddr];
        end
    end

    // Memory keeps its contents through reset; a reset edge abandons any pending write.
    always_ff @(posedge clk) begin
        if (!rst && write_access) begin
            mem[paddr] <= pwdata;
        end
    end

`ifdef APB_SLAVE_PSLVERR_EN
    assign pslverr = !rst && (state == SETUP) && psel && penable;
`endif

endmodule

// File: tb/tb_apb_slave.sv
// Scoreboard bench for apb_slave: read expectations are queued by the driver
// and checked by a monitor that recognises read access cycles on the bus.
module tb_apb_slave;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
`ifdef APB_SLAVE_PSLVERR_EN
    logic              pslverr;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] expected_q [$];
    logic              prev_read_setup = 1'b0;

    apb_slave #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .paddr  (paddr),
        .pwrite (pwrite),
        .psel   (psel),
        .penable(penable),
        .pwdata (pwdata),
`ifdef APB_SLAVE_PSLVERR_EN
        .pslverr(pslverr),
`endif
        .prdata (prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [DATA_W-1:0] actual,
                                input logic [DATA_W-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one bus cycle; inputs change 1 time unit after the rising edge.
    task automatic apply_stimulus(input logic sel, input logic en, input logic wr,
                                  input logic [ADDR_W-1:0] addr,
                                  input logic [DATA_W-1:0] data);
        psel    = sel;
        penable = en;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic write_xfer(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        apply_stimulus(1'b1, 1'b0, 1'b1, addr, data);
        apply_stimulus(1'b1, 1'b1, 1'b1, addr, data);
    endtask

    task automatic read_xfer(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
        expected_q.push_back(exp);
        apply_stimulus(1'b1, 1'b0, 1'b0, addr, '0);
        apply_stimulus(1'b1, 1'b1, 1'b0, addr, '0);
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Monitor: a read access is a psel/penable/!pwrite cycle right after a read setup.
    always @(negedge clk) begin
        if (prev_read_setup && psel && penable && !pwrite && !rst) begin
            tests_run++;
            if (expected_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_read: got 0x%0h, expected no read", prdata);
            end else begin
                logic [DATA_W-1:0] exp;
                exp = expected_q.pop_front();
                if (prdata !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL read_data @0x%0h: got 0x%0h, expected 0x%0h",
                             paddr, prdata, exp);
                end
            end
        end
        prev_read_setup = psel && !penable && !pwrite && !rst;
    end

    initial begin
        rst     = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_prdata", prdata, 32'h0);
`ifdef APB_SLAVE_PSLVERR_EN
        check_output("reset_pslverr", {31'h0, pslverr}, 32'h0);
`endif

        // First setup lands in the very first cycle out of reset.
        rst = 1'b0;
        write_xfer(8'h32, 32'h61);
        read_xfer(8'h32, 32'h61);
        idle_cycle();

        // Access without a setup (psel low during setup) must not write.
        write_xfer(8'h00, 32'hFFFF_FFFF);
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00, 32'hFF);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hFF;
        #2;
`ifdef APB_SLAVE_PSLVERR_EN
        check_output("pslverr_no_setup", {31'h0, pslverr}, 32'h1);
`endif
        @(posedge clk);
        #1;
`ifdef APB_SLAVE_PSLVERR_EN
        idle_cycle();
        check_output("pslverr_cleared", {31'h0, pslverr}, 32'h0);
`endif
        read_xfer(8'h00, 32'hFFFF_FFFF);

        // Read setup followed by a write access must not write.
        write_xfer(8'h10, 32'h99);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h10, 32'hFF);
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h10, 32'hFF);
        read_xfer(8'h10, 32'h99);

        // Back-to-back transfers at the top of the address range.
        write_xfer(8'hFE, 32'h31);
        write_xfer(8'hFF, 32'h32);
        read_xfer(8'hFE, 32'h31);
        read_xfer(8'hFF, 32'h32);
        read_xfer(8'h00, 32'hFFFF_FFFF);

        // prdata holds across writes.
        write_xfer(8'h55, 32'hA5A5_5A5A);
        check_output("prdata_hold_after_write", prdata, 32'hFFFF_FFFF);
        read_xfer(8'h55, 32'hA5A5_5A5A);

        // Penable during SETUP with a write must be ignored.
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h55, 32'h0BAD_0BAD);
        read_xfer(8'h55, 32'hA5A5_5A5A);

        // Reset in the write access cycle abandons the write.
        write_xfer(8'h20, 32'h1234);
        read_xfer(8'h20, 32'h1234);
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'h20, 32'hDEAD);
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h20, 32'hDEAD);
        check_output("prdata_after_mid_reset", prdata, 32'h0);
        rst = 1'b0;
        read_xfer(8'h20, 32'h1234);
        write_xfer(8'h20, 32'hCAFE);
        read_xfer(8'h20, 32'hCAFE);
        idle_cycle();
        idle_cycle();

        check_output("scoreboard_drained", 32'(expected_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameter ADDR_W, default 8, address width; memory depth SHALL be 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, data width of each memory word and of pwdata/prdata.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 paddr  input  ADDR_W  APB word address.
REQ-007 pwrite  input  1  1 = write transfer, 0 = read transfer.
REQ-008 psel  input  1  slave select.
REQ-009 penable  input  1  APB access-phase strobe.
REQ-010 pwdata  input  DATA_W  write data.
REQ-011 prdata  output  DATA_W  registered read data.

Function
REQ-012 The block SHALL contain a 2**ADDR_W x DATA_W register-array memory addressed directly by paddr; there is no wait-state and no pready port.
REQ-013 The FSM SHALL have three states: SETUP, W_ENABLE, R_ENABLE.
REQ-014 SETUP with psel=1, penable=0, pwrite=1 -> W_ENABLE. SETUP with psel=1, penable=0, pwrite=0 -> R_ENABLE, and prdata <= mem[paddr] on that edge. Any other input combination -> stay in SETUP, with no memory or prdata change.
REQ-015 W_ENABLE: when psel=1, penable=1 and pwrite=1, mem[paddr] <= pwdata. Otherwise no write. The next state SHALL be SETUP unconditionally.
REQ-016 R_ENABLE: the next state SHALL be SETUP unconditionally. prdata SHALL hold the value latched in SETUP, so it is valid throughout the access cycle.
REQ-017 prdata SHALL hold its last value until the next read setup. Writes SHALL NOT change prdata.
REQ-018 Back-to-back transfers, with a new setup in the cycle immediately after an access cycle, SHALL be supported with no idle cycle.
REQ-019 Protocol errors SHALL NOT corrupt memory:
- a setup with psel=0 SHALL NOT lead to a write;
- a setup with pwrite=0 followed by an access with pwrite=1 SHALL NOT write;
- penable=1 while in SETUP SHALL be ignored.
REQ-020 Addresses SHALL cover the full range 0..2**ADDR_W-1 with no aliasing. Address 0xFF (ADDR_W=8) SHALL be a valid, distinct location.

Reset
REQ-021 When rst=1 at a clock edge: state <= SETUP and prdata <= 0.
REQ-022 Memory contents SHALL NOT be cleared by reset. Any transfer in progress when reset is applied SHALL be abandoned with no write.
REQ-023 The first transfer setup SHALL be accepted in the first cycle with rst=0.

Configuration
REQ-024 Macro APB_SLAVE_PSLVERR_EN: when defined, the block SHALL add the port "pslverr  output  1".
- pslverr SHALL be 1 during a cycle with psel=1 and penable=1 while the state is SETUP, i.e. an access with no valid setup.
- pslverr SHALL be 0 otherwise, and 0 out of reset.
REQ-025 Without APB_SLAVE_PSLVERR_EN, the pslverr port and its logic SHALL be absent. All other behaviour SHALL be identical with and without the macro.

Verification
REQ-026 Write 0x61 to 0x32, then read 0x32 -> prdata = 0x61 in the read access cycle.
REQ-027 Write 0xFFFF_FFFF to 0x00, then a write of 0xFF to 0x00 with psel=0 during setup, then read 0x00 -> 0xFFFF_FFFF.
REQ-028 Write 0x99 to 0x10, then a write of 0xFF to 0x10 with pwrite=0 during setup, then read 0x10 -> 0x99.
REQ-029 Back-to-back sequence: write 0x31 to 0xFE, write 0x32 to 0xFF, read 0xFE, read 0xFF -> reads return 0x31 and 0x32.
REQ-030 Reset mid-write: assert rst during W_ENABLE -> the location keeps its old value, prdata = 0, and a subsequent transfer succeeds.
REQ-031 With APB_SLAVE_PSLVERR_EN defined: psel=1 and penable=1 with no prior setup -> pslverr = 1 for that cycle and no memory change.
